// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the serial transmit controllers.
package serial_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } seq_state_t;

    localparam int unsigned DEFAULT_WIDTH      = 4;
    localparam int unsigned DEFAULT_DIV        = 1;
    localparam int unsigned DEFAULT_GAP_CYCLES = 0;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit divider: counts DIV cycles per bit and flags the final cycle of each bit.
module bit_timer
    import serial_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o,
    output logic tick_next_o
);

    localparam int unsigned   CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // tick_next_o lets the owner register outputs that coincide with tick_o.
    assign tick_next_o = (cnt_d == LAST);
    assign tick_o      = tick_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_next_o;
        end
    end

endmodule

// File: rtl/piso_tx_sequencer.sv
// Sequences a PISO shift register: accepts a word, issues one load cycle,
// paces WIDTH bits (MSB first) with the bit timer and inserts an optional gap.
module piso_tx_sequencer
    import serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DIV        = DEFAULT_DIV,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     abort,
    output logic                     sr_load_shift,
    output logic                     sr_bit_en,
    output logic [WIDTH-1:0]         sr_data,
    output logic                     ser_valid,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done,
    output logic                     busy
);

    localparam int unsigned   IW       = $clog2(WIDTH);
    localparam int unsigned   GW       = cnt_width(GAP_CYCLES + 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             en_q, en_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tick, tick_next;
    logic             accept, last_bit;

    bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .clear_i     (state_q != SHIFT),
        .en_i        (state_q == SHIFT),
        .tick_o      (tick),
        .tick_next_o (tick_next)
    );

    // done_q marks the final cycle of bit 0; with no gap a new word may be taken then.
    assign in_ready = reset_n && !abort &&
                      ((state_q == IDLE) ||
                       ((GAP_CYCLES == 0) && (state_q == SHIFT) && done_q));
    assign accept   = in_valid && in_ready;
    assign last_bit = tick && (idx_q == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = '0;
        data_d  = accept ? in_data : data_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD;
            end
            LOAD: begin
                state_d = abort ? IDLE : SHIFT;
                idx_d   = TOP_IDX;
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    if (accept)              state_d = LOAD;
                    else if (GAP_CYCLES > 0) state_d = GAP;
                    else                     state_d = IDLE;
                end else if (tick) begin
                    idx_d = idx_q - 1'b1;
                end
            end
            GAP: begin
                if (abort || (gap_q == GAP_LAST)) state_d = IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        load_d  = (state_d == LOAD);
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d != IDLE);
        en_d    = load_d || (valid_d && tick_next && (idx_d != '0));
        done_d  = valid_d && tick_next && (idx_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            load_q  <= load_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sr_load_shift = load_q;
    assign sr_bit_en     = en_q;
    assign sr_data       = data_q;
    assign ser_valid     = valid_q;
    assign bit_idx       = idx_q;
    assign done          = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// Bench for piso_tx_sequencer: two configurations (DIV=1/GAP=0 and DIV=3/GAP=2)
// with behavioural shift registers and a cycle-offset reference model.
module tb_piso_tx_sequencer;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       iv  [2];
    logic       ab  [2];
    logic       rdy [2];
    logic       ls  [2];
    logic       be  [2];
    logic       sv  [2];
    logic       dn  [2];
    logic       bz  [2];
    logic [3:0] id  [2];
    logic [3:0] sd  [2];
    logic [3:0] srm [2];
    logic [1:0] bi  [2];

    int         k     [2];
    logic [3:0] mword [2];
    logic [3:0] mdata [2];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;

    always #5 clk = ~clk;

    piso_tx_sequencer #(.WIDTH(4), .DIV(1), .GAP_CYCLES(0)) u_dut0 (
        .clock(clk), .reset_n(rst[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_data(id[0]), .abort(ab[0]), .sr_load_shift(ls[0]), .sr_bit_en(be[0]),
        .sr_data(sd[0]), .ser_valid(sv[0]), .bit_idx(bi[0]), .done(dn[0]), .busy(bz[0])
    );

    piso_tx_sequencer #(.WIDTH(4), .DIV(3), .GAP_CYCLES(2)) u_dut1 (
        .clock(clk), .reset_n(rst[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_data(id[1]), .abort(ab[1]), .sr_load_shift(ls[1]), .sr_bit_en(be[1]),
        .sr_data(sd[1]), .ser_valid(sv[1]), .bit_idx(bi[1]), .done(dn[1]), .busy(bz[1])
    );

    // Behavioural shift registers: load/shift mux into a flop chain, MSB on the line.
    always @(posedge clk) if (be[0]) srm[0] <= ls[0] ? sd[0] : {srm[0][2:0], 1'b0};
    always @(posedge clk) if (be[1]) srm[1] <= ls[1] ? sd[1] : {srm[1][2:0], 1'b0};

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    typedef struct packed {
        logic       ls;
        logic       be;
        logic       sv;
        logic       dn;
        logic       bz;
        logic       line;
        logic [1:0] bi;
    } exp_t;

    // k = cycles since the accepting edge (1 = LOAD), -1 when idle.
    function automatic exp_t model(input int div, input int kk, input logic [3:0] w);
        exp_t e;
        int   last, n, b;
        e    = '0;
        last = 1 + W * div;
        if (kk >= 1) e.bz = 1'b1;
        if (kk == 1) begin
            e.ls = 1'b1;
            e.be = 1'b1;
        end else if (kk >= 2 && kk <= last) begin
            n      = kk - 2;
            b      = n / div;
            e.sv   = 1'b1;
            e.bi   = 2'(3 - b);
            e.line = w[3 - b];
            e.be   = ((n % div) == (div - 1)) && (b < 3);
            e.dn   = ((n % div) == (div - 1)) && (b == 3);
        end
        return e;
    endfunction

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       ab;
        logic       rdy;
        logic       ls;
        logic       be;
        logic       sv;
        logic       line;
        logic [1:0] bi;
        logic       dn;
    } vec_t;

    function automatic vec_t mk(input logic iv_, input logic [3:0] d_, input logic ab_,
                                input logic rdy_, input logic ls_, input logic be_,
                                input logic sv_, input logic line_, input logic [1:0] bi_,
                                input logic dn_);
        vec_t v;
        v.iv = iv_; v.d = d_; v.ab = ab_; v.rdy = rdy_; v.ls = ls_;
        v.be = be_; v.sv = sv_; v.line = line_; v.bi = bi_; v.dn = dn_;
        return v;
    endfunction

    task automatic chk_bit(input string name, input int d, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%b expected=%b", name, d, cyc, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input int d, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Compare both DUTs against the model for the current cycle, advance the model,
    // then move to just after the next rising edge.
    task automatic step();
        exp_t e;
        logic er;
        int   last;
        #1;
        for (int d = 0; d < 2; d++) begin
            last = 1 + W * div_of(d);
            e    = model(div_of(d), k[d], mword[d]);
            er   = rst[d] && !ab[d] && (k[d] < 0 || (gap_of(d) == 0 && k[d] == last));
            chk_bit("in_ready", d, rdy[d], er);
            chk_bit("sr_load_shift", d, ls[d], e.ls);
            chk_bit("sr_bit_en", d, be[d], e.be);
            chk_bit("ser_valid", d, sv[d], e.sv);
            chk_bit("done", d, dn[d], e.dn);
            chk_bit("busy", d, bz[d], e.bz);
            chk_vec("sr_data", d, sd[d], mdata[d]);
            if (e.sv) begin
                chk_vec("bit_idx", d, {2'b00, bi[d]}, {2'b00, e.bi});
                chk_bit("line", d, srm[d][3], e.line);
            end
            if (!rst[d]) begin
                k[d]     = -1;
                mdata[d] = '0;
            end else if (ab[d] && k[d] >= 1) begin
                k[d] = -1;
            end else if (iv[d] && er) begin
                k[d]     = 1;
                mword[d] = id[d];
                mdata[d] = id[d];
            end else if (k[d] >= 1) begin
                k[d]++;
                if (k[d] > last + gap_of(d)) k[d] = -1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    logic acc;
    int   t_load, t_done, t_acc, nsv, nbe, nbe_ok, n_acc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; iv[d] = 1'b0; ab[d] = 1'b0; id[d] = '0;
            srm[d] = '0; k[d] = -1; mword[d] = '0; mdata[d] = '0;
        end

        // Basic word 4'hA, then back-to-back 4'hC / 4'h3 (DUT0, DIV=1, GAP=0).
        //                  iv    d     ab  rdy ls be sv ln bi dn
        tbl.push_back(mk(1, 4'hA, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 1, 3, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 0, 1, 1, 1, 3, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 0, 1, 1, 1, 2, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 4'h3, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 0, 3, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        foreach (tbl[i]) begin
            iv[0] = tbl[i].iv;
            id[0] = tbl[i].d;
            ab[0] = tbl[i].ab;
            #1;
            chk_bit("vec_in_ready", 0, rdy[0], tbl[i].rdy);
            chk_bit("vec_load", 0, ls[0], tbl[i].ls);
            chk_bit("vec_bit_en", 0, be[0], tbl[i].be);
            chk_bit("vec_ser_valid", 0, sv[0], tbl[i].sv);
            chk_bit("vec_done", 0, dn[0], tbl[i].dn);
            if (tbl[i].sv) begin
                chk_bit("vec_line", 0, srm[0][3], tbl[i].line);
                chk_vec("vec_bit_idx", 0, {2'b00, bi[0]}, {2'b00, tbl[i].bi});
            end
            step();
        end
        iv[0] = 1'b0;

        // Divider: 4'h5 on DUT1 (DIV=3).
        iv[1] = 1'b1; id[1] = 4'h5;
        step();
        iv[1] = 1'b0;
        t_load = -100; t_done = -100; nsv = 0; nbe = 0; nbe_ok = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (ls[1]) t_load = i;
            if (sv[1]) nsv++;
            if (sv[1] && be[1]) begin
                nbe++;
                if ((i - t_load - 1) % 3 == 2) nbe_ok++;
            end
            if (dn[1] && t_done < 0) t_done = i;
            step();
        end
        chk_int("div_valid_cycles", nsv, 12);
        chk_int("div_done_after_load", t_done - t_load, 12);
        chk_int("div_shift_enables", nbe, 3);
        chk_int("div_enable_on_3rd_cycle", nbe_ok, 3);

        // Gap: two words queued on DUT1 (GAP=2).
        iv[1] = 1'b1; id[1] = 4'h3;
        n_acc = 0; t_done = -100; t_acc = -100;
        for (int i = 0; i < 60 && n_acc < 2; i++) begin
            #1;
            acc = rdy[1] && iv[1];
            if (acc) n_acc++;
            if (acc && n_acc == 2) t_acc = i;
            if (dn[1] && t_done < 0) t_done = i;
            step();
            if (acc && n_acc == 1) id[1] = 4'hC;
            if (n_acc == 2) iv[1] = 1'b0;
        end
        iv[1] = 1'b0;
        chk_int("gap_accept_after_done", t_acc - t_done, 3);
        repeat (20) step();

        // Abort while bit_idx = 1.
        iv[0] = 1'b1; id[0] = 4'h9;
        step();
        iv[0] = 1'b0;
        repeat (3) step();
        #1;
        chk_vec("abort_pre_idx", 0, {2'b00, bi[0]}, 4'd1);
        ab[0] = 1'b1;
        step();
        ab[0] = 1'b0;
        #1;
        chk_bit("abort_ser_valid", 0, sv[0], 1'b0);
        chk_bit("abort_no_done", 0, dn[0], 1'b0);
        chk_bit("abort_busy", 0, bz[0], 1'b0);
        chk_bit("abort_in_ready", 0, rdy[0], 1'b1);
        step();

        // Abort together with in_valid in IDLE.
        iv[0] = 1'b1; ab[0] = 1'b1; id[0] = 4'h6;
        #1;
        chk_bit("abort_idle_ready", 0, rdy[0], 1'b0);
        step();
        iv[0] = 1'b0; ab[0] = 1'b0;
        #1;
        chk_bit("abort_idle_no_load", 0, ls[0], 1'b0);
        chk_bit("abort_idle_busy", 0, bz[0], 1'b0);
        step();

        // Reset for one cycle at bit_idx = 2, then send 4'hF.
        iv[0] = 1'b1; id[0] = 4'hA;
        step();
        iv[0] = 1'b0;
        repeat (2) step();
        #1;
        chk_vec("rst_pre_idx", 0, {2'b00, bi[0]}, 4'd2);
        rst[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        #1;
        chk_vec("rst_sr_data", 0, sd[0], 4'h0);
        chk_bit("rst_ser_valid", 0, sv[0], 1'b0);
        chk_bit("rst_busy", 0, bz[0], 1'b0);
        chk_bit("rst_load", 0, ls[0], 1'b0);
        chk_bit("rst_bit_en", 0, be[0], 1'b0);
        chk_bit("rst_done", 0, dn[0], 1'b0);
        chk_vec("rst_bit_idx", 0, {2'b00, bi[0]}, 4'd0);
        step();
        iv[0] = 1'b1; id[0] = 4'hF;
        step();
        iv[0] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_bit("rst_word_F_line", 0, srm[0][3], 1'b1);
            step();
        end
        step();

        // Randomised traffic on both configurations against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d] = ($urandom_range(0, 149) != 0);
                ab[d]  = ($urandom_range(0, 19) == 0);
                iv[d]  = ($urandom_range(0, 2) != 0);
                id[d]  = 4'($urandom);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ab[d] = 1'b0; iv[d] = 1'b0;
        end
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
